// File: rtl/shim_shutdown_pkg.sv
// Shared constants and state type for the shutdown-force latch writer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Contents:
//   N_CH / CH_W  - latch channel count and address width
//   LAST_CH      - highest channel address (round-robin start point after reset)
//   state_t      - S_IDLE / S_SETUP / S_STROBE / S_HOLD write-sequence states
package shim_shutdown_pkg;

    localparam int N_CH = 8;
    localparam int CH_W = 3;

    localparam logic [CH_W-1:0] LAST_CH = CH_W'(N_CH - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_STROBE = 2'd2,
        S_HOLD   = 2'd3
    } state_t;

endpackage

// File: rtl/shim_shutdown_force_if.sv
// Bundle between the shim control registers and the shutdown-force latch writer.
// Latency: n/a (wires only).
// Backpressure: none; the busy flag is informational, requests are level-based.
//
// master : control side; drives enable + requested value, observes latch pins and shadow.
// slave  : the latch writer (shim_shutdown_force).
interface shim_shutdown_force_if;
    import shim_shutdown_pkg::*;

    logic               shutdown_force_en;
    logic [N_CH-1:0]    shutdown_force;
    logic [CH_W-1:0]    shutdown_force_sel;
    logic               shutdown_force_data;
    logic               shutdown_force_le_n;
    logic               shutdown_force_busy;
    logic [N_CH-1:0]    shutdown_force_wr;

    modport master (
        output shutdown_force_en,
        output shutdown_force,
        input  shutdown_force_sel,
        input  shutdown_force_data,
        input  shutdown_force_le_n,
        input  shutdown_force_busy,
        input  shutdown_force_wr
    );

    modport slave (
        input  shutdown_force_en,
        input  shutdown_force,
        output shutdown_force_sel,
        output shutdown_force_data,
        output shutdown_force_le_n,
        output shutdown_force_busy,
        output shutdown_force_wr
    );

endinterface

// File: rtl/shim_shutdown_rr_pick.sv
// Round-robin picker: first set request bit at or after a start index, wrapping.
// Latency: combinational.
// Backpressure: none.
//
// Ports:
//   req   in  N_CH  request vector (one bit per channel)
//   start in  CH_W  channel with highest priority this pick
//   vld   out 1     at least one request bit set
//   ch    out CH_W  chosen channel
module shim_shutdown_rr_pick
    import shim_shutdown_pkg::*;
(
    input  logic [N_CH-1:0] req,
    input  logic [CH_W-1:0] start,
    output logic            vld,
    output logic [CH_W-1:0] ch
);

    logic [2*N_CH-1:0] dbl;
    logic [N_CH-1:0]   rot;
    logic [CH_W-1:0]   off;

    // Rotate so that 'start' lands at bit 0, then lowest set bit wins.
    assign dbl = {req, req} >> start;
    assign rot = dbl[N_CH-1:0];

    always_comb begin
        vld = 1'b0;
        off = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (rot[i]) begin
                vld = 1'b1;
                off = CH_W'(i);
            end
        end
    end

    // Rotate back; CH_W-bit addition wraps modulo N_CH.
    assign ch = start + off;

endmodule

// File: rtl/shim_shutdown_force.sv
// Writes per-channel shutdown values into an external 8-way addressable latch, only for changed channels.
// Latency: request change to latch strobe = 1 + SETUP_CYCLES; to shadow update = 1 + SETUP + STROBE + HOLD cycles.
// Backpressure: none; requests are levels, changes during a write are picked up on a later pass.
//
// Ports:
//   clk  in  system clock
//   rst  in  synchronous active-high reset
//   bus  slave modport of shim_shutdown_force_if:
//        shutdown_force_en (block enable), shutdown_force[8] (requested values) in;
//        shutdown_force_sel[3], _data, _le_n (latch pins), _busy, _wr[8] (committed shadow) out.
// Configuration: define SHUTDOWN_FORCE_REFRESH_EN to keep rewriting channels round-robin even
//   when nothing has changed (continuous latch refresh).
module shim_shutdown_force
    import shim_shutdown_pkg::*;
#(
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 2,
    parameter int HOLD_CYCLES   = 1
)
(
    input  logic                  clk,
    input  logic                  rst,
    shim_shutdown_force_if.slave  bus
);

    localparam int MAX_SS = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
    localparam int MAX_P  = (MAX_SS > HOLD_CYCLES) ? MAX_SS : HOLD_CYCLES;
    localparam int CNT_W  = $clog2(MAX_P + 1);

    // Counters load N-1 and run down to 0, so each phase lasts exactly N cycles.
    localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYCLES - 1);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic [CH_W-1:0]   sel_q;
    logic              data_q;
    logic              le_n_q;
    logic              busy_q;
    logic [N_CH-1:0]   wr_q;
    logic              all_pending;
    logic [CH_W-1:0]   last_ch;

    logic [N_CH-1:0]   dirty;
    logic [CH_W-1:0]   start_ch;
    logic              pick_vld;
    logic [CH_W-1:0]   pick_ch;
    logic              go_vld;
    logic [CH_W-1:0]   go_ch;

    // all_pending forces every channel dirty until a complete 0..7 pass has been committed.
    assign dirty    = (bus.shutdown_force ^ wr_q) | {N_CH{all_pending}};
    assign start_ch = last_ch + CH_W'(1);

    shim_shutdown_rr_pick u_pick (
        .req   (dirty),
        .start (start_ch),
        .vld   (pick_vld),
        .ch    (pick_ch)
    );

`ifdef SHUTDOWN_FORCE_REFRESH_EN
    // Nothing dirty: refresh the next channel in rotation with its current value.
    assign go_vld = 1'b1;
    assign go_ch  = pick_vld ? pick_ch : start_ch;
`else
    assign go_vld = pick_vld;
    assign go_ch  = pick_ch;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cnt         <= '0;
            sel_q       <= '0;
            data_q      <= 1'b0;
            le_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            wr_q        <= '0;
            all_pending <= 1'b1;
            last_ch     <= LAST_CH;
        end else if (!bus.shutdown_force_en) begin
            // Abort/park. The latch contents are now uncertain (a strobe may have
            // been cut short), so schedule a full rewrite starting at channel 0.
            state       <= S_IDLE;
            cnt         <= '0;
            sel_q       <= '0;
            data_q      <= 1'b0;
            le_n_q      <= 1'b1;
            busy_q      <= 1'b0;
            all_pending <= 1'b1;
            last_ch     <= LAST_CH;
        end else begin
            case (state)
                S_IDLE: begin
                    if (go_vld) begin
                        state  <= S_SETUP;
                        cnt    <= SETUP_LD;
                        sel_q  <= go_ch;
                        // Sampled once; later request changes wait for the next pass.
                        data_q <= bus.shutdown_force[go_ch];
                        le_n_q <= 1'b1;
                        busy_q <= 1'b1;
                    end
                end
                S_SETUP: begin
                    if (cnt == '0) begin
                        state  <= S_STROBE;
                        cnt    <= STROBE_LD;
                        le_n_q <= 1'b0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_STROBE: begin
                    if (cnt == '0) begin
                        state  <= S_HOLD;
                        cnt    <= HOLD_LD;
                        le_n_q <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_HOLD: begin
                    if (cnt == '0) begin
                        state        <= S_IDLE;
                        busy_q       <= 1'b0;
                        wr_q[sel_q]  <= data_q;
                        last_ch      <= sel_q;
                        if (sel_q == LAST_CH) begin
                            all_pending <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.shutdown_force_sel  = sel_q;
    assign bus.shutdown_force_data = data_q;
    assign bus.shutdown_force_le_n = le_n_q;
    assign bus.shutdown_force_busy = busy_q;
    assign bus.shutdown_force_wr   = wr_q;

endmodule

// File: tb/tb_shim_shutdown_force.sv
// Bench for shim_shutdown_force: directed scenarios plus randomized run against a timeline model.
// Latency: n/a.
// Backpressure: n/a.
module tb_shim_shutdown_force;

    localparam int S  = 2;
    localparam int ST = 2;
    localparam int H  = 1;
    localparam int L  = S + ST + H;      // cycles a write stays busy
    localparam int WR_CYC = L + 1;       // one write including the idle gap

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    shim_shutdown_force_if bus ();

    shim_shutdown_force #(
        .SETUP_CYCLES  (S),
        .STROBE_CYCLES (ST),
        .HOLD_CYCLES   (H)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model: a write is a timeline of L cycles; le_n is low while the
    // position in that timeline falls in [S, S+ST).
    bit         m_busy;
    int         m_pos;
    logic [2:0] m_sel;
    logic       m_data;
    logic [7:0] m_wr;
    bit         m_pend;
    int         m_last;

    // Latch writes seen on the DUT pins: {sel, data} at each le_n falling edge.
    logic [3:0] dut_log[$];
    logic       prev_le_n = 1'b1;

    function automatic logic exp_le_n();
        return !(m_busy && (m_pos >= S) && (m_pos < S + ST));
    endfunction

    task automatic model_update();
        logic [7:0] frc;
        bit         found;
        int         c;
        frc   = bus.shutdown_force;
        found = 1'b0;
        c     = 0;
        if (rst) begin
            m_busy = 1'b0; m_pos = 0; m_sel = 3'd0; m_data = 1'b0;
            m_wr = 8'h00; m_pend = 1'b1; m_last = 7;
        end else if (!bus.shutdown_force_en) begin
            m_busy = 1'b0; m_pos = 0; m_sel = 3'd0; m_data = 1'b0;
            m_pend = 1'b1; m_last = 7;
        end else if (m_busy) begin
            if (m_pos == L - 1) begin
                m_wr[m_sel] = m_data;
                m_last      = int'(m_sel);
                if (m_sel == 3'd7) m_pend = 1'b0;
                m_busy = 1'b0;
            end else begin
                m_pos++;
            end
        end else begin
            for (int k = 1; k <= 8; k++) begin
                int cc;
                cc = (m_last + k) % 8;
                if (!found && ((frc[cc] !== m_wr[cc]) || m_pend)) begin
                    found = 1'b1;
                    c     = cc;
                end
            end
`ifdef SHUTDOWN_FORCE_REFRESH_EN
            if (!found) begin
                found = 1'b1;
                c     = (m_last + 1) % 8;
            end
`endif
            if (found) begin
                m_busy = 1'b1;
                m_pos  = 0;
                m_sel  = c[2:0];
                m_data = frc[c];
            end
        end
    endtask

    // One clock: model consumes the inputs present at the edge, outputs sampled 1 ns later.
    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        if (prev_le_n && !bus.shutdown_force_le_n)
            dut_log.push_back({bus.shutdown_force_sel, bus.shutdown_force_data});
        prev_le_n = bus.shutdown_force_le_n;
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until le_n is low; ok=0 if the budget expires.
    task automatic wait_strobe(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            step();
            if (!bus.shutdown_force_le_n) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.shutdown_force_en = 1'b0;
        bus.shutdown_force    = 8'h00;
        run(3);
        checks++; if (bus.shutdown_force_sel !== 3'd0) begin errors++; $display("FAIL reset_sel got=%0d exp=0", bus.shutdown_force_sel); end
        checks++; if (bus.shutdown_force_data !== 1'b0) begin errors++; $display("FAIL reset_data got=%b exp=0", bus.shutdown_force_data); end
        checks++; if (bus.shutdown_force_le_n !== 1'b1) begin errors++; $display("FAIL reset_le_n got=%b exp=1", bus.shutdown_force_le_n); end
        checks++; if (bus.shutdown_force_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.shutdown_force_busy); end
        checks++; if (bus.shutdown_force_wr !== 8'h00) begin errors++; $display("FAIL reset_wr got=%h exp=00", bus.shutdown_force_wr); end
        rst = 1'b0;
        run(3);
        checks++; if (bus.shutdown_force_busy !== 1'b0 || bus.shutdown_force_le_n !== 1'b1) begin errors++; $display("FAIL disabled_idle busy=%b le_n=%b exp busy=0 le_n=1", bus.shutdown_force_busy, bus.shutdown_force_le_n); end
    endtask

    task automatic test_full_pass();
        logic [7:0] exp_v;
        exp_v = 8'hA5;
        dut_log.delete();
        bus.shutdown_force_en = 1'b1;
        bus.shutdown_force    = exp_v;
        run(8 * WR_CYC + 5);
        checks++; if (dut_log.size() != 8) begin errors++; $display("FAIL pass_count got=%0d exp=8", dut_log.size()); end
        for (int i = 0; i < 8 && i < dut_log.size(); i++) begin
            checks++;
            if (dut_log[i] !== {3'(i), exp_v[i]}) begin
                errors++; $display("FAIL pass_write%0d got=%h exp=%h", i, dut_log[i], {3'(i), exp_v[i]});
            end
        end
`ifndef SHUTDOWN_FORCE_REFRESH_EN
        checks++; if (bus.shutdown_force_busy !== 1'b0) begin errors++; $display("FAIL pass_busy got=%b exp=0", bus.shutdown_force_busy); end
`endif
        checks++; if (bus.shutdown_force_wr !== exp_v) begin errors++; $display("FAIL pass_wr got=%h exp=%h", bus.shutdown_force_wr, exp_v); end
    endtask

    task automatic test_single_change();
        dut_log.delete();
        bus.shutdown_force = 8'hAD;              // bit3 0->1 in cycle t
        step();                                  // now in t+1
        checks++; if (bus.shutdown_force_busy !== 1'b1 || bus.shutdown_force_sel !== 3'd3 || bus.shutdown_force_data !== 1'b1)
            begin errors++; $display("FAIL lat_setup busy=%b sel=%0d data=%b exp 1/3/1", bus.shutdown_force_busy, bus.shutdown_force_sel, bus.shutdown_force_data); end
        checks++; if (bus.shutdown_force_le_n !== 1'b1) begin errors++; $display("FAIL lat_t1_le_n got=%b exp=1", bus.shutdown_force_le_n); end
        step();                                  // t+2
        checks++; if (bus.shutdown_force_le_n !== 1'b1) begin errors++; $display("FAIL lat_t2_le_n got=%b exp=1", bus.shutdown_force_le_n); end
        step();                                  // t+3
        checks++; if (bus.shutdown_force_le_n !== 1'b0) begin errors++; $display("FAIL lat_t3_le_n got=%b exp=0", bus.shutdown_force_le_n); end
        step();                                  // t+4
        checks++; if (bus.shutdown_force_le_n !== 1'b0) begin errors++; $display("FAIL lat_t4_le_n got=%b exp=0", bus.shutdown_force_le_n); end
        step();                                  // t+5
        checks++; if (bus.shutdown_force_le_n !== 1'b1 || bus.shutdown_force_wr[3] !== 1'b0)
            begin errors++; $display("FAIL lat_t5 le_n=%b wr3=%b exp 1/0", bus.shutdown_force_le_n, bus.shutdown_force_wr[3]); end
        step();                                  // t+6
        checks++; if (bus.shutdown_force_wr[3] !== 1'b1 || bus.shutdown_force_busy !== 1'b0)
            begin errors++; $display("FAIL lat_t6 wr3=%b busy=%b exp 1/0", bus.shutdown_force_wr[3], bus.shutdown_force_busy); end
        run(20);
`ifndef SHUTDOWN_FORCE_REFRESH_EN
        checks++; if (dut_log.size() != 1) begin errors++; $display("FAIL lat_one_write got=%0d exp=1", dut_log.size()); end
`endif
    endtask

    task automatic test_mid_strobe();
        bit ok;
        bit seen_bad;
        bus.shutdown_force = 8'hA5;
        run(3 * WR_CYC);
        dut_log.delete();
        bus.shutdown_force = 8'hAD;
        wait_strobe(4 * WR_CYC, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_wait_strobe got=timeout exp=strobe"); end
        bus.shutdown_force = 8'hA5;              // change back during strobe
        seen_bad = 1'b0;
        for (int i = 0; i < L && bus.shutdown_force_busy; i++) begin
            if (bus.shutdown_force_sel !== 3'd3 || bus.shutdown_force_data !== 1'b1) seen_bad = 1'b1;
            step();
        end
        checks++; if (seen_bad) begin errors++; $display("FAIL mid_hold_stable got=changed exp=sel3_data1"); end
        run(3 * WR_CYC);
        checks++; if (dut_log.size() < 2 || dut_log[0] !== {3'd3, 1'b1} || dut_log[1] !== {3'd3, 1'b0})
            begin errors++; $display("FAIL mid_two_writes got_n=%0d exp writes 7 then 6", dut_log.size()); end
        checks++; if (bus.shutdown_force_wr !== 8'hA5) begin errors++; $display("FAIL mid_wr got=%h exp=a5", bus.shutdown_force_wr); end
    endtask

    task automatic test_starvation();
        int pos6;
        logic [7:0] f;
        dut_log.delete();
        pos6 = -1;
        f = 8'hA5 ^ 8'h40;                       // bit6 changes once
        for (int i = 0; i < 10 * WR_CYC && pos6 < 0; i++) begin
            f[0] = ~f[0];                        // neighbour toggles every cycle
            bus.shutdown_force = f;
            step();
            for (int j = 0; j < dut_log.size(); j++)
                if (pos6 < 0 && dut_log[j][3:1] == 3'd6) pos6 = j;
        end
        checks++; if (pos6 < 0 || pos6 >= 8) begin errors++; $display("FAIL starve_ch6 got_pos=%0d exp=<8", pos6); end
        checks++; if (pos6 >= 0 && dut_log[pos6][0] !== 1'b1) begin errors++; $display("FAIL starve_data got=%b exp=1", dut_log[pos6][0]); end
        bus.shutdown_force = 8'hE5;
        run(4 * WR_CYC);
        checks++; if (bus.shutdown_force_wr !== 8'hE5) begin errors++; $display("FAIL starve_settle got=%h exp=e5", bus.shutdown_force_wr); end
    endtask

    task automatic test_en_drop();
        bit ok;
        logic [7:0] wr_exp;
        logic [7:0] nv;
        nv = 8'h3C;
        bus.shutdown_force = nv;
        wait_strobe(4 * WR_CYC, ok);
        checks++; if (!ok) begin errors++; $display("FAIL drop_wait_strobe got=timeout exp=strobe"); end
        wr_exp = m_wr;
        bus.shutdown_force_en = 1'b0;
        step();
        checks++; if (bus.shutdown_force_le_n !== 1'b1 || bus.shutdown_force_busy !== 1'b0)
            begin errors++; $display("FAIL drop_park le_n=%b busy=%b exp 1/0", bus.shutdown_force_le_n, bus.shutdown_force_busy); end
        checks++; if (bus.shutdown_force_sel !== 3'd0 || bus.shutdown_force_data !== 1'b0)
            begin errors++; $display("FAIL drop_pins sel=%0d data=%b exp 0/0", bus.shutdown_force_sel, bus.shutdown_force_data); end
        checks++; if (bus.shutdown_force_wr !== wr_exp) begin errors++; $display("FAIL drop_wr got=%h exp=%h", bus.shutdown_force_wr, wr_exp); end
        run(4);
        dut_log.delete();
        bus.shutdown_force_en = 1'b1;
        run(8 * WR_CYC + 2);
        checks++; if (dut_log.size() < 8) begin errors++; $display("FAIL reen_count got=%0d exp=8", dut_log.size()); end
        for (int i = 0; i < 8 && i < dut_log.size(); i++) begin
            checks++;
            if (dut_log[i] !== {3'(i), nv[i]}) begin
                errors++; $display("FAIL reen_write%0d got=%h exp=%h", i, dut_log[i], {3'(i), nv[i]});
            end
        end
        checks++; if (bus.shutdown_force_wr !== nv) begin errors++; $display("FAIL reen_wr got=%h exp=%h", bus.shutdown_force_wr, nv); end
    endtask

    task automatic test_refresh();
        logic [7:0] fv;
        bit         seq_ok;
        fv = 8'h0F;
        bus.shutdown_force = fv;
        run(9 * WR_CYC);
        dut_log.delete();
        run(60);
`ifdef SHUTDOWN_FORCE_REFRESH_EN
        seq_ok = 1'b1;
        for (int i = 0; i < dut_log.size(); i++) begin
            if (dut_log[i][0] !== fv[dut_log[i][3:1]]) seq_ok = 1'b0;
            if (i > 0 && dut_log[i][3:1] !== dut_log[i-1][3:1] + 3'd1) seq_ok = 1'b0;
        end
        checks++; if (dut_log.size() < 9) begin errors++; $display("FAIL refresh_count got=%0d exp>=9", dut_log.size()); end
        checks++; if (!seq_ok) begin errors++; $display("FAIL refresh_order got=out_of_order exp=cyclic"); end
`else
        seq_ok = bus.shutdown_force_le_n;
        checks++; if (dut_log.size() != 0) begin errors++; $display("FAIL quiet_count got=%0d exp=0", dut_log.size()); end
        checks++; if (seq_ok !== 1'b1) begin errors++; $display("FAIL quiet_le_n got=%b exp=1", seq_ok); end
`endif
        checks++; if (bus.shutdown_force_wr !== fv) begin errors++; $display("FAIL refresh_wr got=%h exp=%h", bus.shutdown_force_wr, fv); end
    endtask

    task automatic test_random();
        logic [7:0] f;
        int r;
        f = bus.shutdown_force;
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 999));
            rst = 1'b0;
            if (r < 80)
                f[$urandom_range(0, 7)] = ~f[$urandom_range(0, 7)];
            else if (r < 90)
                bus.shutdown_force_en = 1'b0;
            else if (r < 200 && !bus.shutdown_force_en)
                bus.shutdown_force_en = 1'b1;
            else if (r < 203)
                rst = 1'b1;
            bus.shutdown_force = f;
            step();
            checks++; if (bus.shutdown_force_sel !== m_sel) begin errors++; $display("FAIL rand_sel cyc=%0d got=%0d exp=%0d", cyc, bus.shutdown_force_sel, m_sel); end
            checks++; if (bus.shutdown_force_data !== m_data) begin errors++; $display("FAIL rand_data cyc=%0d got=%b exp=%b", cyc, bus.shutdown_force_data, m_data); end
            checks++; if (bus.shutdown_force_le_n !== exp_le_n()) begin errors++; $display("FAIL rand_le_n cyc=%0d got=%b exp=%b", cyc, bus.shutdown_force_le_n, exp_le_n()); end
            checks++; if (bus.shutdown_force_busy !== m_busy) begin errors++; $display("FAIL rand_busy cyc=%0d got=%b exp=%b", cyc, bus.shutdown_force_busy, m_busy); end
            checks++; if (bus.shutdown_force_wr !== m_wr) begin errors++; $display("FAIL rand_wr cyc=%0d got=%h exp=%h", cyc, bus.shutdown_force_wr, m_wr); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.shutdown_force_en = 1'b0;
        bus.shutdown_force    = 8'h00;
        test_reset();
        test_full_pass();
        test_single_change();
        test_mid_strobe();
        test_starvation();
        test_en_drop();
        test_refresh();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
